// File: rtl/game_sequencer.sv
// game_sequencer: debounced buttons, game FSM, player/bullet/score and enemy pacing for the VGA shooter
module game_sequencer #(
  parameter int DEB_CYCLES  = 227800,
  parameter int SCREEN_W    = 640,
  parameter int PLAYER_W    = 32,
  parameter int PLAYER_Y    = 448,
  parameter int PLAYER_STEP = 4,
  parameter int BULLET_STEP = 8,
  parameter int ENEMY_DIV   = 30
) (
  input  logic       CLK22_78MHZ,
  input  logic       rstN,
  input  logic       pbR,
  input  logic       pbL,
  input  logic       pbG,
  input  logic       frame_start,
  input  logic       hit_enemy,
  input  logic       enemy_reached,
  input  logic [5:0] enemies_left,
  output logic [1:0] state,
  output logic [9:0] player_x,
  output logic       bullet_active,
  output logic [9:0] bullet_x,
  output logic [9:0] bullet_y,
  output logic       enemy_step,
  output logic [9:0] score
);
  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int FW = $clog2(ENEMY_DIV + 1);
  localparam logic [9:0] X_MAX  = 10'(SCREEN_W - PLAYER_W);
  localparam logic [9:0] X_MID  = 10'((SCREEN_W - PLAYER_W) / 2);
  localparam logic [9:0] P_STEP = 10'(PLAYER_STEP);
  localparam logic [9:0] B_STEP = 10'(BULLET_STEP);
  localparam logic [9:0] B_Y    = 10'(PLAYER_Y);
  localparam logic [9:0] B_OFF  = 10'(PLAYER_W / 2 - 1);
  typedef enum logic [1:0] {IDLE = 2'b00, PLAY = 2'b01, WIN = 2'b10, LOSE = 2'b11} state_t;
  state_t r_state, w_next;
  logic [2:0] w_pin, w_deb, w_press;
  logic [9:0] r_px, r_bx, r_by, r_score, w_px_next, w_score_inc;
  logic [FW-1:0] r_fcnt;
  logic r_bact, r_step, w_rgt, w_lft, w_exit, w_g;
  assign w_pin = {pbG, pbL, pbR};
  // Per button: 2-FF synchronizer, then a level accepted only after DEB_CYCLES differing samples
  for (genvar b = 0; b < 3; b++) begin : g_deb
    logic r_s1, r_s2, r_lvl, r_lvl_q;
    logic [DW-1:0] r_cnt;
    always_ff @(posedge CLK22_78MHZ or negedge rstN)
      if (!rstN) begin
        r_s1    <= 1'b1;
        r_s2    <= 1'b1;
        r_lvl   <= 1'b1;
        r_lvl_q <= 1'b1;
        r_cnt   <= '0;
      end else begin
        r_s1    <= w_pin[b];
        r_s2    <= r_s1;
        r_lvl_q <= r_lvl;
        if (r_s2 == r_lvl) r_cnt <= '0;
        else if (r_cnt == DW'(DEB_CYCLES - 1)) begin
          r_lvl <= r_s2;
          r_cnt <= '0;
        end else r_cnt <= r_cnt + 1'b1;
      end
    assign w_deb[b]   = r_lvl;
    assign w_press[b] = r_lvl_q & ~r_lvl;
  end
  assign w_g   = w_press[2];
  assign w_rgt = ~w_deb[0] & w_deb[1];
  assign w_lft = ~w_deb[1] & w_deb[0];
  assign w_exit = enemy_reached | (enemies_left == 6'd0);
  assign w_px_next = w_rgt ? ((r_px >= X_MAX - P_STEP) ? X_MAX : r_px + P_STEP) :
                     w_lft ? ((r_px < P_STEP) ? 10'd0 : r_px - P_STEP) : r_px;
  assign w_score_inc = (r_score >= 10'd999) ? 10'd999 : r_score + 10'd1;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_g ? PLAY : IDLE;
      PLAY:    w_next = enemy_reached ? LOSE : (enemies_left == 6'd0) ? WIN : PLAY;
      default: w_next = w_g ? IDLE : r_state;
    endcase
  end
  always_ff @(posedge CLK22_78MHZ or negedge rstN)
    if (!rstN) r_state <= IDLE;
    else r_state <= w_next;
  always_ff @(posedge CLK22_78MHZ or negedge rstN)
    if (!rstN) begin
      r_px    <= X_MID;
      r_bact  <= 1'b0;
      r_bx    <= '0;
      r_by    <= '0;
      r_step  <= 1'b0;
      r_score <= '0;
      r_fcnt  <= '0;
    end else begin
      r_step <= 1'b0;
      if (r_state == IDLE && w_g) begin
        r_px    <= X_MID;
        r_score <= '0;
        r_bact  <= 1'b0;
        r_fcnt  <= '0;
      end else if (r_state == PLAY) begin
        if (w_exit) r_bact <= 1'b0;
        else begin
          if (frame_start) begin
            r_px   <= w_px_next;
            r_fcnt <= (r_fcnt == FW'(ENEMY_DIV - 1)) ? '0 : r_fcnt + 1'b1;
            r_step <= (r_fcnt == FW'(ENEMY_DIV - 1));
          end
          // A hit retires the bullet before any frame move; firing needs an idle bullet
          if (r_bact && hit_enemy) begin
            r_bact  <= 1'b0;
            r_score <= w_score_inc;
          end else if (r_bact && frame_start) begin
            if (r_by < B_STEP) r_bact <= 1'b0;
            else r_by <= r_by - B_STEP;
          end else if (!r_bact && w_g) begin
            r_bact <= 1'b1;
            r_bx   <= r_px + B_OFF;
            r_by   <= B_Y;
          end
        end
      end
    end
  assign state         = r_state;
  assign player_x      = r_px;
  assign bullet_active = r_bact;
  assign bullet_x      = r_bx;
  assign bullet_y      = r_by;
  assign enemy_step    = r_step;
  assign score         = r_score;
endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: directed plus random stimulus against a rule-level game model
module tb_game_sequencer;
  localparam int DEB = 4;
  localparam int DIV = 3;
  logic clk = 1'b0;
  logic rstN = 1'b0, pbR = 1'b1, pbL = 1'b1, pbG = 1'b1;
  logic frame_start = 1'b0, hit_enemy = 1'b0, enemy_reached = 1'b0;
  logic [5:0] enemies_left = 6'd20;
  logic [1:0] state;
  logic [9:0] player_x, bullet_x, bullet_y, score;
  logic bullet_active, enemy_step;
  int n_cmp = 0, n_bad = 0, n_steps = 0;
  int m_state, m_px, m_bact, m_bx, m_by, m_step, m_score, m_frames, old_px;
  bit m_deb[3], m_press[3], hist[3][DEB+2], pins[3];
  bit g, r, l, was, diff;

  always #5 clk = ~clk;

  game_sequencer #(.DEB_CYCLES(DEB), .ENEMY_DIV(DIV)) dut (
    .CLK22_78MHZ(clk), .rstN(rstN), .pbR(pbR), .pbL(pbL), .pbG(pbG),
    .frame_start(frame_start), .hit_enemy(hit_enemy), .enemy_reached(enemy_reached),
    .enemies_left(enemies_left), .state(state), .player_x(player_x),
    .bullet_active(bullet_active), .bullet_x(bullet_x), .bullet_y(bullet_y),
    .enemy_step(enemy_step), .score(score)
  );

  function automatic void m_reset();
    m_state = 0; m_px = 304; m_bact = 0; m_bx = 0; m_by = 0;
    m_step = 0; m_score = 0; m_frames = 0;
    for (int b = 0; b < 3; b++) begin
      m_deb[b] = 1; m_press[b] = 0;
      for (int i = 0; i < DEB + 2; i++) hist[b][i] = 1;
    end
  endfunction

  // Model: game rules in plain arithmetic; a button level flips once the last DEB
  // samples, seen through two cycles of synchronizer delay, all disagree with it
  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rstN);
      if (!rstN) m_reset();
      else begin
        g = m_press[2]; r = !m_deb[0]; l = !m_deb[1];
        m_step = 0;
        if (m_state == 0) begin
          if (g) begin m_state = 1; m_px = 304; m_score = 0; m_bact = 0; m_frames = 0; end
        end else if (m_state == 1) begin
          if (enemy_reached || enemies_left == 0) begin
            m_state = enemy_reached ? 3 : 2; m_bact = 0;
          end else begin
            was = m_bact[0]; old_px = m_px;
            if (frame_start) begin
              if (r && !l) m_px = (m_px + 4 > 608) ? 608 : m_px + 4;
              if (l && !r) m_px = (m_px - 4 < 0) ? 0 : m_px - 4;
              m_frames++;
              if (m_frames % DIV == 0) m_step = 1;
            end
            if (was && hit_enemy) begin
              m_bact = 0; m_score = (m_score + 1 > 999) ? 999 : m_score + 1;
            end else if (was && frame_start) begin
              if (m_by < 8) m_bact = 0; else m_by -= 8;
            end else if (!was && g) begin
              m_bact = 1; m_bx = old_px + 15; m_by = 448;
            end
          end
        end else if (g) m_state = 0;
        pins[0] = pbR; pins[1] = pbL; pins[2] = pbG;
        for (int b = 0; b < 3; b++) begin
          diff = 1;
          for (int i = 1; i <= DEB; i++) if (hist[b][i] == m_deb[b]) diff = 0;
          m_press[b] = 0;
          if (diff) begin m_deb[b] = !m_deb[b]; m_press[b] = !m_deb[b]; end
          for (int i = DEB + 1; i > 0; i--) hist[b][i] = hist[b][i-1];
          hist[b][0] = pins[b];
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    n_cmp++;
    if (enemy_step) n_steps++;
    if (int'(state) != m_state || int'(player_x) != m_px || int'(bullet_active) != m_bact ||
        int'(bullet_x) != m_bx || int'(bullet_y) != m_by || int'(enemy_step) != m_step ||
        int'(score) != m_score) begin
      n_bad++;
      $display("FAIL cycle t=%0t got st=%0d px=%0d ba=%0d bx=%0d by=%0d es=%0d sc=%0d want st=%0d px=%0d ba=%0d bx=%0d by=%0d es=%0d sc=%0d",
               $time, state, player_x, bullet_active, bullet_x, bullet_y, enemy_step, score,
               m_state, m_px, m_bact, m_bx, m_by, m_step, m_score);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic hold(input logic rv, input logic lv);
    pbR = rv; pbL = lv; tick(10);
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      frame_start = 1'b1; tick(1); frame_start = 1'b0;
      tick(int'($urandom_range(1, 4)));
    end
  endtask

  task automatic press_g();
    pbG = 1'b0; tick(10); pbG = 1'b1; tick(10);
  endtask

  initial begin
    tick(3);
    chk("reset state", state, 0);
    chk("reset player_x", player_x, 304);
    chk("reset score", score, 0);
    chk("reset bullet_active", bullet_active, 0);
    chk("reset enemy_step", enemy_step, 0);
    rstN = 1'b1;
    tick(2);
    pbG = 1'b0; tick(3); pbG = 1'b1; tick(10);
    chk("glitch ignored", state, 0);
    pbG = 1'b0; tick(6);
    chk("start not before 7", state, 0);
    tick(1);
    chk("start at 7", state, 1);
    n_steps = 0;
    tick(3); pbG = 1'b1; tick(10);
    hold(1'b0, 1'b1); frames(80);
    chk("right saturate", player_x, 608);
    hold(1'b0, 1'b0); frames(10);
    chk("both no move", player_x, 608);
    chk("enemy_step per 3 frames", n_steps, 30);
    hold(1'b1, 1'b0); frames(200);
    chk("left saturate", player_x, 0);
    hold(1'b0, 1'b1); frames(76); hold(1'b1, 1'b1);
    chk("back to centre", player_x, 304);
    press_g();
    chk("fire active", bullet_active, 1);
    chk("fire x", bullet_x, 319);
    chk("fire y", bullet_y, 448);
    frames(3);
    chk("bullet y after 3", bullet_y, 424);
    hit_enemy = 1'b1; tick(1); hit_enemy = 1'b0; tick(1);
    chk("hit clears", bullet_active, 0);
    chk("hit score", score, 1);
    press_g(); frames(56);
    chk("bullet at top", bullet_y, 0);
    chk("bullet alive at top", bullet_active, 1);
    frames(1);
    chk("bullet self clear", bullet_active, 0);
    enemies_left = 6'd0; enemy_reached = 1'b1; tick(2);
    chk("lose priority", state, 3);
    enemy_reached = 1'b0; enemies_left = 6'd20;
    press_g();
    chk("lose to idle", state, 0);
    press_g();
    chk("restart play", state, 1);
    chk("restart score", score, 0);
    hold(1'b1, 1'b0); frames(51); hold(1'b1, 1'b1);
    chk("player at 100", player_x, 100);
    press_g();
    chk("bullet before reset", bullet_active, 1);
    @(posedge clk); #3; rstN = 1'b0; #1;
    chk("async reset state", state, 0);
    chk("async reset player_x", player_x, 304);
    chk("async reset bullet", bullet_active, 0);
    tick(2); rstN = 1'b1;
    repeat (4000) begin
      if ($urandom_range(0, 11) == 0) pbR = ~pbR;
      if ($urandom_range(0, 11) == 0) pbL = ~pbL;
      if ($urandom_range(0, 9) == 0) pbG = ~pbG;
      frame_start   = ($urandom_range(0, 5) == 0);
      hit_enemy     = ($urandom_range(0, 9) == 0);
      enemy_reached = ($urandom_range(0, 599) == 0);
      enemies_left  = ($urandom_range(0, 399) == 0) ? 6'd0 : 6'($urandom_range(1, 40));
      tick(1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
